exmem_skid_latch: RTL and testbench

Parametrised successor to the fixed EX/MEM pipeline latch. Replaces the single always-load register with a 2-entry valid/ready skid buffer that carries a generic data payload and control bundle. Adds stall via backpressure, flush-to-bubble, debug-step gating, sticky halt capture and a retired-transfer counter. Sits between the EX and MEM stages, or between any two pipeline stages that need elastic decoupling.

---
 rtl/exmem_skid_latch.sv | 141 ++++++++++++++
 tb/tb_exmem_skid_latch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_skid_latch.sv
// exmem_skid_latch: two-entry valid/ready skid buffer between pipeline stages.
// Holds a head (main) entry and a skid entry so the upstream ready never
// depends combinationally on the downstream ready. Adds flush-to-bubble,
// debug-step gating, sticky halt capture and a retired-transfer counter.
module exmem_skid_latch #(
  parameter int DATA_BITS = 128,
  parameter int CTRL_BITS = 16,
  parameter int HALT_BIT  = 15,
  parameter int CNT_BITS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [CTRL_BITS-1:0] i_ctrl,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic [CTRL_BITS-1:0] o_ctrl,
  output logic [1:0]           o_count,
  output logic                 o_halted,
  output logic [CNT_BITS-1:0]  o_xfer_cnt
);

  // Occupancy encoding doubles as the o_count value.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] main_data_reg, main_data_next;
  logic [CTRL_BITS-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_BITS-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_BITS-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic                 halted_reg, halted_next;
  logic [CNT_BITS-1:0]  xfer_cnt_reg, xfer_cnt_next;

  logic head_valid;
  logic can_accept;
  logic in_xfer;
  logic out_xfer;

  // Handshake decode; only registered state (and reset) feeds the outputs.
  assign head_valid = (state_reg != EMPTY);
  assign can_accept = (state_reg != FULL) & ~halted_reg & i_reset;
  assign in_xfer    = i_valid & can_accept & i_step;
  assign out_xfer   = head_valid & i_ready & i_step & i_reset;

  assign o_ready    = can_accept;
  assign o_valid    = head_valid & i_reset;
  assign o_data     = i_reset ? main_data_reg : '0;
  assign o_ctrl     = (head_valid & i_reset) ? main_ctrl_reg : '0;
  assign o_count    = i_reset ? state_reg : 2'd0;
  assign o_halted   = halted_reg;
  assign o_xfer_cnt = xfer_cnt_reg;

  // Next-state logic: flush wins over loads, but a same-cycle output still retires.
  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    halted_next    = halted_reg;
    xfer_cnt_next  = xfer_cnt_reg;

    if (i_step) begin
      if (out_xfer) begin
        xfer_cnt_next = xfer_cnt_reg + CNT_BITS'(1);
        if (main_ctrl_reg[HALT_BIT]) begin
          halted_next = 1'b1;
        end
      end

      if (i_flush) begin
        // Turn everything held into a bubble; data may stay stale.
        state_next     = EMPTY;
        main_ctrl_next = '0;
        skid_ctrl_next = '0;
      end else begin
        case (state_reg)
          EMPTY: begin
            if (in_xfer) begin
              main_data_next = i_data;
              main_ctrl_next = i_ctrl;
              state_next     = ONE;
            end
          end
          ONE: begin
            if (in_xfer && !out_xfer) begin
              skid_data_next = i_data;
              skid_ctrl_next = i_ctrl;
              state_next     = FULL;
            end else if (out_xfer && !in_xfer) begin
              state_next = EMPTY;
            end else if (in_xfer && out_xfer) begin
              main_data_next = i_data;
              main_ctrl_next = i_ctrl;
            end
          end
          FULL: begin
            // Upstream is blocked here, so only a drain is possible.
            if (out_xfer) begin
              main_data_next = skid_data_reg;
              main_ctrl_next = skid_ctrl_reg;
              state_next     = ONE;
            end
          end
          default: state_next = EMPTY;
        endcase
      end
    end
  end

  // State registers with synchronous active-low reset that overrides i_step.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      halted_reg    <= 1'b0;
      xfer_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      halted_reg    <= halted_next;
      xfer_cnt_reg  <= xfer_cnt_next;
    end
  end

endmodule

// File: tb/tb_exmem_skid_latch.sv
// Directed testbench for exmem_skid_latch with hand-computed expectations.
module tb_exmem_skid_latch;

  localparam int DB = 128;
  localparam int CB = 16;
  localparam int NB = 4;

  logic          i_clk;
  logic          i_reset;
  logic          i_step;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DB-1:0] i_data;
  logic [CB-1:0] i_ctrl;
  logic          o_valid;
  logic          i_ready;
  logic [DB-1:0] o_data;
  logic [CB-1:0] o_ctrl;
  logic [1:0]    o_count;
  logic          o_halted;
  logic [NB-1:0] o_xfer_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DB-1:0] base;
  logic [DB-1:0] d1, d2, d3;
  logic [NB-1:0] exp_xfer;

  exmem_skid_latch #(
    .DATA_BITS(DB),
    .CTRL_BITS(CB),
    .HALT_BIT (15),
    .CNT_BITS (NB)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_step    (i_step),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_ctrl    (i_ctrl),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_ctrl    (o_ctrl),
    .o_count   (o_count),
    .o_halted  (o_halted),
    .o_xfer_cnt(o_xfer_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Compare one observed value with its expected value and log the transaction.
  task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    base     = {16{8'hA5}};
    d1       = {4{32'h1111_0001}};
    d2       = {4{32'h2222_0002}};
    d3       = {4{32'h3333_0003}};
    i_reset  = 1'b0;
    i_step   = 1'b1;
    i_flush  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data   = '0;
    i_ctrl   = '0;
    exp_xfer = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", DB'(o_valid), DB'(1'b0));
    chk("rst_ready", DB'(o_ready), DB'(1'b0));
    chk("rst_count", DB'(o_count), DB'(0));
    chk("rst_data", o_data, '0);
    chk("rst_xfer", DB'(o_xfer_cnt), DB'(0));
    chk("rst_halted", DB'(o_halted), DB'(1'b0));
    i_reset = 1'b1;
    #1;
    chk("rel_ready", DB'(o_ready), DB'(1'b1));

    // Streaming at full throughput: one new head per cycle
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = base ^ DB'(k);
      i_ctrl = CB'(k + 1);
      tick();
      chk($sformatf("stream%0d_valid", k), DB'(o_valid), DB'(1'b1));
      chk($sformatf("stream%0d_data", k), o_data, base ^ DB'(k));
      chk($sformatf("stream%0d_count", k), DB'(o_count), DB'(1));
    end
    exp_xfer = 4'd3;
    chk("stream_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));
    i_valid = 1'b0;
    tick();
    exp_xfer = 4'd4;
    chk("drain_count", DB'(o_count), DB'(0));
    chk("drain_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));

    // Backpressure fills both entries, then drains in order
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = d1; i_ctrl = 16'h0001;
    tick();
    i_data  = d2; i_ctrl = 16'h0002;
    tick();
    chk("bp_count", DB'(o_count), DB'(2));
    chk("bp_ready", DB'(o_ready), DB'(1'b0));
    chk("bp_data_d1", o_data, d1);
    i_data  = d3; i_ctrl = 16'h0003;
    tick();
    chk("bp_hold_count", DB'(o_count), DB'(2));
    chk("bp_hold_data", o_data, d1);
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    exp_xfer = 4'd5;
    chk("bp_data_d2", o_data, d2);
    chk("bp_ctrl_d2", DB'(o_ctrl), DB'(16'h0002));
    chk("bp_count1", DB'(o_count), DB'(1));
    tick();
    exp_xfer = 4'd6;
    chk("bp_empty_valid", DB'(o_valid), DB'(1'b0));
    chk("bp_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));

    // Flush while FULL with an entry offered on the input
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = d1; i_ctrl = 16'h0011;
    tick();
    i_data  = d2; i_ctrl = 16'h0012;
    tick();
    chk("fl_full", DB'(o_count), DB'(2));
    i_data  = d3; i_ctrl = 16'h0013;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("fl_count", DB'(o_count), DB'(0));
    chk("fl_valid", DB'(o_valid), DB'(1'b0));
    chk("fl_ctrl", DB'(o_ctrl), DB'(0));
    chk("fl_ready", DB'(o_ready), DB'(1'b1));
    chk("fl_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));
    tick();
    chk("fl_no_ghost", DB'(o_valid), DB'(1'b0));

    // Flush coinciding with an output transfer still retires it
    i_valid = 1'b1;
    i_data  = d3; i_ctrl = 16'h0021;
    tick();
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    exp_xfer = 4'd7;
    chk("flo_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));
    chk("flo_count", DB'(o_count), DB'(0));

    // Debug step low freezes everything, even with flush and traffic
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = d2; i_ctrl = 16'h0031;
    tick();
    i_step  = 1'b0;
    i_ready = 1'b1;
    i_data  = d1; i_ctrl = 16'h0032;
    for (int k = 0; k < 5; k++) begin
      i_flush = (k == 2);
      tick();
      chk($sformatf("step%0d_data", k), o_data, d2);
      chk($sformatf("step%0d_count", k), DB'(o_count), DB'(1));
      chk($sformatf("step%0d_xfer", k), DB'(o_xfer_cnt), DB'(exp_xfer));
    end
    i_flush = 1'b0;
    i_step  = 1'b1;
    i_valid = 1'b0;
    tick();
    exp_xfer = 4'd8;
    chk("step_resume_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));
    chk("step_resume_count", DB'(o_count), DB'(0));

    // Halt entry retires, then nothing more is accepted
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = d3; i_ctrl = 16'h8000;
    tick();
    chk("halt_ctrl", DB'(o_ctrl), DB'(16'h8000));
    chk("halt_pre", DB'(o_halted), DB'(1'b0));
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    exp_xfer = 4'd9;
    chk("halt_set", DB'(o_halted), DB'(1'b1));
    chk("halt_ready", DB'(o_ready), DB'(1'b0));
    i_valid = 1'b1;
    i_data  = d1; i_ctrl = 16'h0041;
    tick();
    tick();
    chk("halt_block_valid", DB'(o_valid), DB'(1'b0));
    chk("halt_block_xfer", DB'(o_xfer_cnt), DB'(exp_xfer));
    chk("halt_sticky", DB'(o_halted), DB'(1'b1));

    // Reset clears halt; then 17 transfers wrap the 4-bit counter to 1
    i_valid = 1'b0;
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    #1;
    chk("rst2_halted", DB'(o_halted), DB'(1'b0));
    chk("rst2_ready", DB'(o_ready), DB'(1'b1));
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      i_data = base ^ DB'(k << 8);
      tick();
    end
    chk("wrap_xfer", DB'(o_xfer_cnt), DB'(4'd1));

    // Reset pulse mid-stream while FULL
    i_ready = 1'b0;
    tick();
    chk("mid_full", DB'(o_count), DB'(2));
    i_reset = 1'b0;
    #1;
    chk("mid_rst_ready", DB'(o_ready), DB'(1'b0));
    chk("mid_rst_valid", DB'(o_valid), DB'(1'b0));
    tick();
    chk("mid_rst_data", o_data, '0);
    chk("mid_rst_ctrl", DB'(o_ctrl), DB'(0));
    chk("mid_rst_count", DB'(o_count), DB'(0));
    chk("mid_rst_xfer", DB'(o_xfer_cnt), DB'(0));
    i_reset = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("mid_rel_ready", DB'(o_ready), DB'(1'b1));
    chk("mid_rel_count", DB'(o_count), DB'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
